// File: rtl/id_ex_shift_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_shift_stage
// Brief    : ID/EX pipeline register for the ARM-subset datapath. Resolves
//            operand forwarding at capture time and presents Execute with
//            registered shifter controls, operands and control bits.
//            Supports hazard-unit stall (hold) and flush (bubble).
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_shift_stage #(
    parameter int DW = 32,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [31:0]   id_instr,
    input  logic [DW-1:0] id_rn_val,
    input  logic [DW-1:0] id_rm_val,
    input  logic [1:0]    fwd_sel_rn,
    input  logic [1:0]    fwd_sel_rm,
    input  logic [DW-1:0] ex_fwd,
    input  logic [DW-1:0] mem_fwd,
    input  logic [DW-1:0] wb_fwd,
    input  logic [3:0]    id_alu_op,
    input  logic          id_s_bit,
    input  logic          id_load,
    input  logic          id_store,
    input  logic          id_rf_en,
    output logic          ex_valid,
    output logic [3:0]    ex_cond,
    output logic [2:0]    ex_shifter_op,
    output logic [1:0]    ex_by_imm_shift,
    output logic [11:0]   ex_shift_field,
    output logic          ex_u_bit,
    output logic [DW-1:0] ex_shift_a,
    output logic [DW-1:0] ex_rn_val,
    output logic [RW-1:0] ex_rd,
    output logic [3:0]    ex_alu_op,
    output logic          ex_s_bit,
    output logic          ex_load,
    output logic          ex_store,
    output logic          ex_rf_en
);

    localparam logic [1:0] c_SEL_RF  = 2'b00;
    localparam logic [1:0] c_SEL_EX  = 2'b01;
    localparam logic [1:0] c_SEL_MEM = 2'b10;

    logic [DW-1:0] w_rn_fwd;
    logic [DW-1:0] w_rm_fwd;
    logic          w_bubble;
    logic          w_capture;

    // Forwarding mux for Rn: picks the youngest valid copy named by the hazard unit
    always_comb begin
        w_rn_fwd = id_rn_val;
        case (fwd_sel_rn)
            c_SEL_RF:  w_rn_fwd = id_rn_val;
            c_SEL_EX:  w_rn_fwd = ex_fwd;
            c_SEL_MEM: w_rn_fwd = mem_fwd;
            default:   w_rn_fwd = wb_fwd;
        endcase
    end

    // Forwarding mux for Rm, which feeds the shifter A input
    always_comb begin
        w_rm_fwd = id_rm_val;
        case (fwd_sel_rm)
            c_SEL_RF:  w_rm_fwd = id_rm_val;
            c_SEL_EX:  w_rm_fwd = ex_fwd;
            c_SEL_MEM: w_rm_fwd = mem_fwd;
            default:   w_rm_fwd = wb_fwd;
        endcase
    end

    // Flush wins over stall; an empty Decode slot only bubbles when not stalled
    always_comb begin
        w_bubble  = flush | (~id_valid & ~stall);
        w_capture = ~flush & ~stall & id_valid;
    end

    // Stage register: bubble clears everything (shift-by-0 no-op), stall holds,
    // capture slices instruction fields directly and latches forwarded operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid        <= 1'b0;
            ex_cond         <= '0;
            ex_shifter_op   <= '0;
            ex_by_imm_shift <= '0;
            ex_shift_field  <= '0;
            ex_u_bit        <= 1'b0;
            ex_shift_a      <= '0;
            ex_rn_val       <= '0;
            ex_rd           <= '0;
            ex_alu_op       <= '0;
            ex_s_bit        <= 1'b0;
            ex_load         <= 1'b0;
            ex_store        <= 1'b0;
            ex_rf_en        <= 1'b0;
        end else if (w_bubble) begin
            ex_valid        <= 1'b0;
            ex_cond         <= '0;
            ex_shifter_op   <= '0;
            ex_by_imm_shift <= '0;
            ex_shift_field  <= '0;
            ex_u_bit        <= 1'b0;
            ex_shift_a      <= '0;
            ex_rn_val       <= '0;
            ex_rd           <= '0;
            ex_alu_op       <= '0;
            ex_s_bit        <= 1'b0;
            ex_load         <= 1'b0;
            ex_store        <= 1'b0;
            ex_rf_en        <= 1'b0;
        end else if (w_capture) begin
            ex_valid        <= 1'b1;
            ex_cond         <= id_instr[31:28];
            ex_shifter_op   <= id_instr[27:25];
            ex_by_imm_shift <= id_instr[6:5];
            ex_shift_field  <= id_instr[11:0];
            ex_u_bit        <= id_instr[23];
            ex_shift_a      <= w_rm_fwd;
            ex_rn_val       <= w_rn_fwd;
            ex_rd           <= id_instr[12 +: RW];
            ex_alu_op       <= id_alu_op;
            ex_s_bit        <= id_s_bit;
            ex_load         <= id_load;
            ex_store        <= id_store;
            ex_rf_en        <= id_rf_en;
        end
    end

endmodule
`default_nettype wire

// File: doc/id_ex_shift_stage.md
# id_ex_shift_stage

ID/EX pipeline register for the pipelined ARM-subset datapath. It latches the decoded instruction and register operands at the end of Decode. It resolves operand forwarding at capture time, then presents the Execute stage with registered shifter controls (shifter_op, by_imm_shift, 12-bit immediate field, shifter input A) and the ALU/memory/writeback control bits. It supports pipeline stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
Parameters:
- DW, 32, datapath width of operand buses
- RW, 4, register address width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold all stage contents
- flush  in  1  load a bubble on the next edge
- id_valid  in  1  Decode holds a real instruction
- id_instr  in  32  raw instruction word
- id_rn_val  in  DW  register-file value of Rn
- id_rm_val  in  DW  register-file value of Rm
- fwd_sel_rn  in  2  Rn source: 00 id_rn_val, 01 ex_fwd, 10 mem_fwd, 11 wb_fwd
- fwd_sel_rm  in  2  Rm source, same encoding
- ex_fwd, mem_fwd, wb_fwd  in  DW each  forwarded results from EX, MEM and WB
- id_alu_op  in  4  ALU opcode
- id_s_bit, id_load, id_store, id_rf_en  in  1 each  decoded control bits
- ex_valid  out  1  stage holds a real instruction
- ex_cond  out  4  instr[31:28]
- ex_shifter_op  out  3  instr[27:25]
- ex_by_imm_shift  out  2  instr[6:5]
- ex_shift_field  out  12  instr[11:0]
- ex_u_bit  out  1  instr[23]
- ex_shift_a  out  DW  forwarded Rm, the shifter A input
- ex_rn_val  out  DW  forwarded Rn, the ALU first operand
- ex_rd  out  RW  instr[15:12]
- ex_alu_op  out  4
- ex_s_bit, ex_load, ex_store, ex_rf_en  out  1 each

## Operation
- Capture: on each rising edge with no reset, no flush and no stall, every output register loads its ID-side source.
  - Instruction fields are sliced directly from id_instr, with no re-encoding. ex_shifter_op values: 000 shift by immediate, 001 rotated 32-bit immediate, 010 immediate offset, 011 register offset. 1xx values pass through unchanged; the shifter ignores them.
- Forwarding mux: combinational on the ID side and applied before capture. ex_shift_a is captured from the source named by fwd_sel_rm; ex_rn_val from the source named by fwd_sel_rn. The mux output is not registered separately.
- Bubble: loaded when flush=1, or when id_valid=0 with no stall.
  - ex_valid, ex_s_bit, ex_load, ex_store and ex_rf_en are set to 0.
  - All other outputs are set to 0, so ex_shifter_op = 000 and ex_shift_field = 0, which gives shift-by-0, a no-op.
- Stall: when stall=1 and flush=0, every output holds its value and forwarded inputs are ignored. The stalled instruction must re-capture forwarded values when stall drops; forwarding values are not frozen in the register.
- Priority: rst_n low > flush > stall > capture. Flush during stall produces a bubble.

## Timing
- Reset: while rst_n=0, all outputs are 0 immediately, with no clock needed (ex_valid=0, ex_shifter_op=000, ex_shift_a=0). Deassertion is synchronous to the design's reset synchronizer; the first capture happens on the first rising edge with rst_n=1.
- Latency: one cycle. ID inputs valid before edge N appear on the outputs after edge N.
- Reset mid-stream: the in-flight instruction is dropped, and no partial fields are retained.
- Back-to-back instructions: a new instruction every cycle, with no throughput penalty.
- Stall of k cycles: outputs remain constant for k edges, then capture on the first edge with stall=0.
- Flush and id_valid=0 in the same cycle: a single bubble, identical to either alone.
- All outputs come directly from flops, with no combinational path from input to output.

## Test plan
- Reset: assert rst_n=0 mid-cycle with ex_valid=1 -> all outputs are 0 before the next edge. Release, then drive id_instr=32'hE1A01062 with id_valid=1 -> after 1 edge: ex_shifter_op=000, ex_by_imm_shift=11, ex_shift_field=12'h062, ex_rd=1, ex_cond=E, ex_valid=1.
- Immediate forms: id_instr=32'hE3A004FF -> ex_shifter_op=001, ex_shift_field=12'h4FF. Then id_instr=32'hE5912004 -> ex_shifter_op=010, ex_u_bit=1, ex_load passed from id_load=1.
- Forwarding: id_rm_val=1, ex_fwd=2, mem_fwd=3, wb_fwd=4, with fwd_sel_rm stepping 00/01/10/11 on consecutive cycles -> ex_shift_a reads 1, 2, 3, 4, each one cycle later. Repeat for Rn -> ex_rn_val.
- Stall: capture instruction X, then hold stall=1 for 3 cycles while changing all inputs -> outputs equal X for 3 edges. Drop stall with a new value on the selected forward source -> that new value is captured.
- Flush: flush=1 together with stall=1 and id_valid=1 -> next edge gives ex_valid=0, ex_rf_en=0, ex_store=0, ex_shift_field=0. Then flush=0 with id_valid=0 -> the bubble persists.
- Back-to-back: 8 random valid instructions with no stall or flush -> each instruction's outputs match its decode exactly one cycle later, and no cycle is skipped.
